mem_arbiter: RTL and testbench

- Single-port RAM arbiter between the instruction-fetch requester and the data-memory requester of the pipelined datapath.
- A registered grant FSM gives one requester the RAM port at a time and returns wait/load handshakes to both.
- Data has priority (it backs the MEM-stage stall).
- A streak counter guarantees instruction fetch is not starved by back-to-back data traffic.

---
 rtl/mem_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: data requester has priority, instruction fetch is protected from starvation.
// Latency: one arbitration cycle in IDLE, then one or more grant cycles until ram_ready; one bubble between grants.
// Backpressure: iwait/dwait stay high until the granted access sees ram_ready; the loser keeps waiting.
module mem_arbiter #(
  parameter int MAX_D_STREAK = 4,
  parameter int ADDR_W       = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [ADDR_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [ADDR_W-1:0] dstore,
  output logic              dwait,
  output logic [ADDR_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [ADDR_W-1:0] ramstore,
  input  logic [ADDR_W-1:0] ramload,
  input  logic              ram_ready,
  output logic [2:0]        d_streak
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } state_t;

  localparam logic [2:0] MAX_S = 3'(MAX_D_STREAK);

  state_t     state_q, state_d;
  logic [2:0] streak_q, streak_d;
  logic       d_req;

  assign d_req    = dREN | dWEN;
  assign d_streak = streak_q;

  // State and streak registers; reset drops straight to IDLE so strobes fall without a clock.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      streak_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
    end
  end

  // Next state: data wins in IDLE unless instruction has waited through MAX_D_STREAK data accesses.
  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    case (state_q)
      IDLE: begin
        if (d_req && !(iREN && (streak_q >= MAX_S))) begin
          state_d = DGRANT;
        end else if (iREN) begin
          state_d = IGRANT;
        end
      end
      DGRANT: begin
        if (!d_req) begin
          // Requester withdrew: abort without counting it as a completed access.
          state_d = IDLE;
        end else if (ram_ready) begin
          state_d = IDLE;
          if (iREN) begin
            streak_d = (streak_q >= MAX_S) ? MAX_S : streak_q + 3'd1;
          end else begin
            streak_d = 3'd0;
          end
        end
      end
      IGRANT: begin
        if (!iREN) begin
          state_d = IDLE;
        end else if (ram_ready) begin
          state_d  = IDLE;
          streak_d = 3'd0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs: RAM port follows the granted requester; the other side simply waits.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = iREN;
    dwait    = d_req;
    iload    = '0;
    dload    = '0;
    case (state_q)
      DGRANT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        // A simultaneous read+write request is served as the write.
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        dwait    = ~ram_ready;
        dload    = ramload;
      end
      IGRANT: begin
        ramaddr = iaddr;
        // Gated by iREN so a dropped fetch releases the strobe in the same cycle.
        ramREN  = iREN;
        iwait   = ~ram_ready;
        iload   = ramload;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed cycle checks plus a queue scoreboard of expected completions.
// A small RAM model answers the arbiter's port; expectations come from a separate reference image.
// All DUT outputs are sampled on the falling edge; stimulus changes 1 ns after the rising edge.
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN, ram_ready;
  logic [31:0] iaddr, daddr, dstore;
  logic        iwait, dwait, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore, ramload;
  logic [2:0]  d_streak;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t        iq[$];
  exp_t        dq[$];
  logic [31:0] ram_mem [0:255];
  logic [31:0] ref_mem [0:255];
  int          n_chk  = 0;
  int          n_pass = 0;
  int          wr_cnt = 0;

  int exp_g [12] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 2, 0, 1};
  int exp_s [12] = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 0, 0};

  mem_arbiter #(.MAX_D_STREAK(4), .ADDR_W(32)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready), .d_streak(d_streak)
  );

  always #5 CLK = ~CLK;

  assign ramload = ram_mem[ramaddr[9:2]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic mid();
    @(negedge CLK);
  endtask

  function automatic logic [31:0] seed_word(input int i);
    if (i == 16) return 32'h2008_0005;
    return 32'hA500_0000 ^ (32'(i) * 32'h0101_0013);
  endfunction

  function automatic int grant_of();
    if (!ramREN && !ramWEN) return 0;
    if (ramaddr == 32'h104) return 1;
    if (ramaddr == 32'h48) return 2;
    return 3;
  endfunction

  // RAM model and scoreboard: pop an expectation whenever a requester completes.
  always @(negedge CLK) begin
    exp_t e;
    if (nRST) begin
      if (iREN && !iwait) begin
        if (iq.size() == 0) chk("i_unexpected", 32'd1, 32'd0);
        else begin
          e = iq.pop_front();
          chk("i_addr", ramaddr, e.addr);
          chk("iload", iload, e.data);
        end
      end
      if ((dREN || dWEN) && !dwait) begin
        if (dq.size() == 0) chk("d_unexpected", 32'd1, 32'd0);
        else begin
          e = dq.pop_front();
          chk("d_addr", ramaddr, e.addr);
          if (e.wr) begin
            chk("d_wen", 32'(ramWEN), 32'd1);
            chk("ramstore", ramstore, e.data);
          end else begin
            chk("dload", dload, e.data);
          end
        end
      end
    end
    if (ramWEN && ram_ready) begin
      ram_mem[ramaddr[9:2]] = ramstore;
      wr_cnt++;
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ram_ready = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0;
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = seed_word(i);
      ref_mem[i] = seed_word(i);
    end

    // Reset state
    mid();
    chk("rst_ramREN", 32'(ramREN), 32'd0);
    chk("rst_ramWEN", 32'(ramWEN), 32'd0);
    chk("rst_ramaddr", ramaddr, 32'd0);
    chk("rst_ramstore", ramstore, 32'd0);
    chk("rst_streak", 32'(d_streak), 32'd0);
    chk("rst_iload", iload, 32'd0);
    chk("rst_dload", dload, 32'd0);
    iREN = 1'b1; dREN = 1'b1;
    #1;
    chk("rst_iwait", 32'(iwait), 32'd1);
    chk("rst_dwait", 32'(dwait), 32'd1);
    iREN = 1'b0; dREN = 1'b0;
    step();
    nRST = 1'b1;

    // Instruction fetch alone
    iREN = 1'b1; iaddr = 32'h40; ram_ready = 1'b1;
    iq.push_back('{1'b0, 32'h40, 32'h2008_0005});
    mid();
    chk("if_c1_ramREN", 32'(ramREN), 32'd0);
    chk("if_c1_iwait", 32'(iwait), 32'd1);
    step(); mid();
    chk("if_c2_ramREN", 32'(ramREN), 32'd1);
    chk("if_c2_ramaddr", ramaddr, 32'h40);
    chk("if_c2_iwait", 32'(iwait), 32'd0);
    step();
    iREN = 1'b0;
    mid();
    chk("if_c3_ramREN", 32'(ramREN), 32'd0);

    // Simultaneous requests: data first, then instruction
    step();
    iREN = 1'b1; iaddr = 32'h44; dREN = 1'b1; daddr = 32'h100;
    dq.push_back('{1'b0, 32'h100, ref_mem[64]});
    iq.push_back('{1'b0, 32'h44, ref_mem[17]});
    mid();
    chk("sim_arb_ramREN", 32'(ramREN), 32'd0);
    chk("sim_arb_dwait", 32'(dwait), 32'd1);
    step(); mid();
    chk("sim_d_ramaddr", ramaddr, 32'h100);
    chk("sim_d_iwait", 32'(iwait), 32'd1);
    chk("sim_d_streak", 32'(d_streak), 32'd0);
    step();
    dREN = 1'b0;
    mid();
    chk("sim_idle_streak", 32'(d_streak), 32'd1);
    chk("sim_idle_ramREN", 32'(ramREN), 32'd0);
    step(); mid();
    chk("sim_i_ramaddr", ramaddr, 32'h44);
    chk("sim_i_ramREN", 32'(ramREN), 32'd1);
    step();
    iREN = 1'b0;
    mid();
    chk("sim_end_streak", 32'(d_streak), 32'd0);

    // Write/read conflict, then read back the written word
    step();
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h200; dstore = 32'hDEAD_BEEF;
    ref_mem[128] = 32'hDEAD_BEEF;
    dq.push_back('{1'b1, 32'h200, 32'hDEAD_BEEF});
    mid();
    step(); mid();
    chk("wr_ramWEN", 32'(ramWEN), 32'd1);
    chk("wr_ramREN", 32'(ramREN), 32'd0);
    chk("wr_ramstore", ramstore, 32'hDEAD_BEEF);
    step();
    dWEN = 1'b0;
    dq.push_back('{1'b0, 32'h200, ref_mem[128]});
    mid();
    step(); mid();
    chk("rd_ramREN", 32'(ramREN), 32'd1);
    step();
    dREN = 1'b0;
    mid();

    // Starvation guard: four data grants, then one instruction grant
    step();
    iREN = 1'b1; iaddr = 32'h48; dREN = 1'b1; daddr = 32'h104;
    for (int k = 0; k < 4; k++) dq.push_back('{1'b0, 32'h104, ref_mem[65]});
    iq.push_back('{1'b0, 32'h48, ref_mem[18]});
    dq.push_back('{1'b0, 32'h104, ref_mem[65]});
    for (int c = 0; c < 12; c++) begin
      if (c > 0) step();
      mid();
      chk($sformatf("stv_grant_c%0d", c), 32'(grant_of()), 32'(exp_g[c]));
      chk($sformatf("stv_streak_c%0d", c), 32'(d_streak), 32'(exp_s[c]));
    end
    step();
    iREN = 1'b0; dREN = 1'b0;
    mid();
    chk("stv_end_streak", 32'(d_streak), 32'd1);

    // Abort of a stalled instruction fetch
    step();
    iREN = 1'b1; iaddr = 32'h4C; ram_ready = 1'b0;
    mid();
    for (int k = 0; k < 3; k++) begin
      step(); mid();
      chk($sformatf("ab_ramREN_%0d", k), 32'(ramREN), 32'd1);
      chk($sformatf("ab_iwait_%0d", k), 32'(iwait), 32'd1);
    end
    step();
    iREN = 1'b0;
    #1;
    chk("ab_ramREN_drop", 32'(ramREN), 32'd0);
    mid();
    step(); mid();
    chk("ab_idle_streak", 32'(d_streak), 32'd1);
    chk("ab_idle_ramREN", 32'(ramREN), 32'd0);

    // Reset in the middle of a stalled write
    step();
    dWEN = 1'b1; daddr = 32'h208; dstore = 32'h1234_5678;
    mid();
    step(); mid();
    chk("rm_ramWEN_before", 32'(ramWEN), 32'd1);
    #2;
    nRST = 1'b0;
    #1;
    chk("rm_ramWEN_async", 32'(ramWEN), 32'd0);
    chk("rm_ramaddr", ramaddr, 32'd0);
    chk("rm_streak", 32'(d_streak), 32'd0);
    chk("rm_wr_count", 32'(wr_cnt), 32'd1);
    dWEN = 1'b0;
    step();
    nRST = 1'b1;
    dREN = 1'b1; daddr = 32'h208; ram_ready = 1'b1;
    dq.push_back('{1'b0, 32'h208, ref_mem[130]});
    mid();
    step(); mid();
    step();
    dREN = 1'b0;
    mid();

    chk("iq_drained", 32'(iq.size()), 32'd0);
    chk("dq_drained", 32'(dq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
